// File: rtl/ram_bist_ctrl_if.sv
// RAM-side bus of the BIST controller: one synchronous single-port RAM.
interface ram_bist_ctrl_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic              write_enable;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;

    modport master (output write_enable, output address, output data_in, input data_out);
    modport slave  (input write_enable, input address, input data_in, output data_out);
endinterface

// File: rtl/ram_bist_ctrl.sv
// Write-then-read BIST for a single-port RAM: fills every word with addr^seed,
// reads it back, counts mismatching addresses and records the first one.
module ram_bist_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] seed,
    ram_bist_ctrl_if.master   ram,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_fail_addr
);
    localparam int STAGES = 1;
    localparam logic [ADDR_W-1:0] LAST    = '1;
    localparam logic [ADDR_W:0]   ERR_MAX = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              busy;
        logic              done;
        logic              pass;
        logic [ADDR_W:0]   err;
        logic [ADDR_W-1:0] ffa;
        logic [DATA_W-1:0] seed;
    } regs_t;

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] s);
        return DATA_W'(a) ^ s;
    endfunction

    state_t            state, state_nxt;
    regs_t             r, r_nxt;
    logic [STAGES:0]   vld_pipe;
    logic [ADDR_W-1:0] addr_d;
    logic              miss;

    // Read data returns one cycle after the address, so the valid flag and
    // the address travel one stage behind the issued read.
    assign vld_pipe[0] = (state == READ);
    assign miss        = vld_pipe[STAGES] && (ram.data_out != pat(addr_d, r.seed));

    always_comb begin
        state_nxt = state;
        r_nxt     = r;
        if (miss) begin
            if (r.err != ERR_MAX) r_nxt.err = r.err + 1'b1;
            if (r.err == '0)      r_nxt.ffa = addr_d;
        end
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = WRITE;
                    r_nxt.seed  = seed;
                    r_nxt.err   = '0;
                    r_nxt.ffa   = '0;
                    r_nxt.done  = 1'b0;
                    r_nxt.pass  = 1'b0;
                    r_nxt.busy  = 1'b1;
                    r_nxt.we    = 1'b1;
                    r_nxt.addr  = '0;
                    r_nxt.wdata = pat('0, seed);
                end
            end
            WRITE: begin
                if (r.addr == LAST) begin
                    state_nxt  = READ;
                    r_nxt.we   = 1'b0;
                    r_nxt.addr = '0;
                end else begin
                    r_nxt.addr  = r.addr + 1'b1;
                    r_nxt.wdata = pat(r.addr + 1'b1, r.seed);
                end
            end
            READ: begin
                if (r.addr == LAST) state_nxt  = DRAIN;
                else                r_nxt.addr = r.addr + 1'b1;
            end
            DRAIN: begin
                // Last compare lands on this edge; pass must include it.
                state_nxt  = DONE;
                r_nxt.busy = 1'b0;
                r_nxt.done = 1'b1;
                r_nxt.pass = (r_nxt.err == '0);
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            r                  <= '0;
            vld_pipe[STAGES:1] <= '0;
            addr_d             <= '0;
        end else begin
            state              <= state_nxt;
            r                  <= r_nxt;
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            addr_d             <= r.addr;
        end
    end

    assign ram.write_enable = r.we;
    assign ram.address      = r.addr;
    assign ram.data_in      = r.wdata;
    assign busy             = r.busy;
    assign done             = r.done;
    assign pass             = r.pass;
    assign err_count        = r.err;
    assign first_fail_addr  = r.ffa;
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM model with per-address read corruption,
// vector table, randomized runs against a counting model, reset corner cases.
module tb_ram_bist_ctrl;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] seed;
    logic          busy, done, pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_fail_addr;

    ram_bist_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

    ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .ram(ram),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_addr(first_fail_addr)
    );

    always #5 clk = ~clk;

    // RAM model; flip_mask XORs into read data to plant faults
    logic [DW-1:0] mem       [DEPTH];
    logic [DW-1:0] flip_mask [DEPTH];
    logic [DW-1:0] rd_q;
    always @(posedge clk) begin
        if (ram.write_enable) mem[ram.address] <= ram.data_in;
        else                  rd_q <= mem[ram.address] ^ flip_mask[ram.address];
    end
    assign ram.data_out = rd_q;

    // write monitor: edge number and data of the latest write per address
    int            cyc = 0;
    int            wr_total = 0;
    int            wr_edge [DEPTH];
    logic [DW-1:0] wr_data [DEPTH];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram.write_enable) begin
            wr_data[ram.address] <= ram.data_in;
            wr_edge[ram.address] <= cyc + 1;
            wr_total             <= wr_total + 1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic clear_mask();
        for (int i = 0; i < DEPTH; i++) flip_mask[i] = '0;
    endtask

    // Reference: every address whose read is corrupted counts once.
    task automatic model(output int err, output int ffa);
        err = 0;
        ffa = 0;
        for (int a = DEPTH - 1; a >= 0; a--)
            if (flip_mask[a] != 0) begin
                err++;
                ffa = a;
            end
        if (err > DEPTH) err = DEPTH;
    endtask

    task automatic run(input logic [DW-1:0] s, input bit pulse,
                       output int err_o, output int ffa_o, output bit pass_o);
        int e0, w0, nbad;
        bit got;
        @(posedge clk); #1;
        start = 1'b1;
        seed  = s;
        w0    = wr_total;
        @(posedge clk); #1;
        e0    = cyc;
        start = 1'b0;
        seed  = DW'($urandom);
        chk("start_busy", busy, 1);
        chk("start_we", ram.write_enable, 1);
        chk("start_addr", ram.address, 0);
        chk("start_data_in", ram.data_in, s);
        chk("start_err_clr", err_count, 0);
        chk("start_ffa_clr", first_fail_addr, 0);
        chk("start_done_clr", done, 0);
        chk("start_pass_clr", pass, 0);
        got = 1'b0;
        for (int k = 0; k < 3000 && !got; k++) begin
            @(posedge clk); #1;
            start = pulse && (cyc == e0 + 499);
            if (start) seed = ~s;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("done_seen", got, 1);
        chk("done_latency", cyc - e0, 2049);
        chk("done_busy", busy, 0);
        chk("write_count", wr_total - w0, DEPTH);
        nbad = 0;
        for (int a = 0; a < DEPTH; a++)
            if (wr_data[a] !== (DW'(a) ^ s) || wr_edge[a] != e0 + 1 + a) nbad++;
        chk("write_pattern_timing", nbad, 0);
        chk("write_55_data", wr_data[55], DW'(55) ^ s);
        err_o  = err_count;
        ffa_o  = first_fail_addr;
        pass_o = pass;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_done", done, 1);
        chk("hold_err", err_count, err_o);
        chk("hold_ffa", first_fail_addr, ffa_o);
        chk("hold_pass", pass, pass_o);
    endtask

    typedef struct {
        logic [DW-1:0] seed;
        int            bad_a;
        int            bad_b;
        logic [DW-1:0] flip;
        bit            pulse;
        int            exp_err;
        int            exp_ffa;
        bit            exp_pass;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int  e, f, me, mf, k, e0;
        bit  p;
        logic [DW-1:0] s;

        vecs[0] = '{8'h56, -1,   -1,  8'h00, 1'b0, 0, 0,  1'b1};
        vecs[1] = '{8'h56, 55,   -1,  8'h01, 1'b0, 1, 55, 1'b0};
        vecs[2] = '{8'h56, 10,   900, 8'h80, 1'b0, 2, 10, 1'b0};
        vecs[3] = '{8'hFF, -1,   -1,  8'h00, 1'b0, 0, 0,  1'b1};
        vecs[4] = '{8'h3C, -1,   -1,  8'h00, 1'b1, 0, 0,  1'b1};
        vecs[5] = '{8'h00, 1023, 0,   8'hFF, 1'b0, 2, 0,  1'b0};

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        clear_mask();
        rst_n = 1'b0;
        start = 1'b0;
        seed  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", ram.write_enable, 0);
        chk("rst_addr", ram.address, 0);
        chk("rst_data_in", ram.data_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_err", err_count, 0);
        chk("rst_ffa", first_fail_addr, 0);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_we", ram.write_enable, 0);

        for (int v = 0; v < 6; v++) begin
            clear_mask();
            if (vecs[v].bad_a >= 0) flip_mask[vecs[v].bad_a] = vecs[v].flip;
            if (vecs[v].bad_b >= 0) flip_mask[vecs[v].bad_b] = vecs[v].flip;
            run(vecs[v].seed, vecs[v].pulse, e, f, p);
            chk($sformatf("vec%0d_err", v), e, vecs[v].exp_err);
            chk($sformatf("vec%0d_ffa", v), f, vecs[v].exp_ffa);
            chk($sformatf("vec%0d_pass", v), p, vecs[v].exp_pass);
        end

        // every read corrupted: count saturates at DEPTH
        for (int i = 0; i < DEPTH; i++) flip_mask[i] = 8'h01;
        run(8'h77, 1'b0, e, f, p);
        model(me, mf);
        chk("sat_err", e, me);
        chk("sat_err_const", e, DEPTH);
        chk("sat_pass", p, 0);

        for (int r = 0; r < 4; r++) begin
            clear_mask();
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) flip_mask[$urandom_range(0, DEPTH - 1)] = DW'($urandom_range(1, 255));
            s = DW'($urandom);
            run(s, 1'b0, e, f, p);
            model(me, mf);
            chk($sformatf("rnd%0d_err", r), e, me);
            chk($sformatf("rnd%0d_ffa", r), f, mf);
            chk($sformatf("rnd%0d_pass", r), p, (me == 0));
        end

        // asynchronous reset in the middle of READ
        clear_mask();
        flip_mask[10] = 8'h01;
        @(posedge clk); #1;
        start = 1'b1;
        seed  = 8'h5A;
        @(posedge clk); #1;
        e0    = cyc;
        start = 1'b0;
        while (cyc < e0 + 1500) begin
            @(posedge clk); #1;
        end
        chk("midread_err", err_count, 1);
        chk("midread_ffa", first_fail_addr, 10);
        rst_n = 1'b0;
        #1;
        chk("arst_we", ram.write_enable, 0);
        chk("arst_addr", ram.address, 0);
        chk("arst_data_in", ram.data_in, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        chk("arst_pass", pass, 0);
        chk("arst_err", err_count, 0);
        chk("arst_ffa", first_fail_addr, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_we", ram.write_enable, 0);
        chk("post_rst_addr", ram.address, 0);
        clear_mask();
        run(8'h5A, 1'b0, e, f, p);
        chk("post_rst_pass", p, 1);
        chk("post_rst_err", e, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
